load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Byte-addressed RV32I load/store front end for the 32-word data_memory. Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW
//  request at a time from the execute stage, drives the memory's word read/write ports and returns sign/zero-
//  extended load data or a store ack. Sub-word stores use read-modify-write, since the memory is word-wide only.
// PARAMETERS
//  WORD_AW    5    word address width; memory depth = 2**WORD_AW words, byte range 0..(4*2**WORD_AW - 1)
// PORTS
//  clk             in   1        single clock, rising edge
//  reset           in   1        asynchronous, active-low reset
//  req_valid       in   1        request present
//  req_ready       out  1        unit can accept; high only in IDLE
//  req_we          in   1        1 = store, 0 = load
//  req_funct3      in   3        RISC-V funct3 size/sign code
//  req_addr        in   32       byte address
//  req_wdata       in   32       store data; low byte/half used for SB/SH
//  resp_valid      out  1        one-cycle pulse: load data or store ack
//  resp_rdata      out  32       extended load data; 0 for stores and errors
//  resp_err        out  1        misaligned, out-of-range or illegal funct3; valid with resp_valid
//  mem_read_addr   out  WORD_AW  to data_memory read port
//  mem_write_addr  out  WORD_AW  to data_memory write port
//  mem_write_data  out  32       to data_memory
//  mem_sw          out  1        data_memory store enable
//  mem_read_data   in   32       from data_memory; valid the cycle after mem_read_addr is presented
// BEHAVIOUR
//  - Reset: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, captured regs 0; mem_sw=0 immediately (comb. from state).
//  - Handshake: accept when req_valid & req_ready; one outstanding request; no resp backpressure.
//  - Legal funct3: loads 000 LB,001 LH,010 LW,100 LBU,101 LHU; stores 000 SB,001 SH,010 SW. Anything else -> err.
//  - Error = illegal funct3 | (half & addr[0]) | (word & addr[1:0]!=0) | addr[31:WORD_AW+2]!=0.
//    Error request: no mem_sw, resp_valid at T+1 with resp_err=1, resp_rdata=0.
//  - FSM states IDLE, LD_WAIT, RMW_WAIT.
//    IDLE: mem_read_addr=req_addr[WORD_AW+1:2] (comb.) always. On accept at cycle T:
//      load -> LD_WAIT; SW -> mem_sw=1 in T with mem_write_data=req_wdata, stay IDLE, ack at T+1;
//      SB/SH -> RMW_WAIT (read of target word issued in T); error -> stay IDLE, err resp at T+1.
//      Capture addr[1:0], funct3, wdata, word addr on accept.
//    LD_WAIT (T+1): select byte/half by captured offset from mem_read_data; sign-extend (LB/LH) or
//      zero-extend (LBU/LHU); register into resp_rdata -> resp_valid=1 at T+2; -> IDLE.
//    RMW_WAIT (T+1): merged = mem_read_data with lane(s) replaced by wdata[7:0] (SB, lane addr[1:0]) or
//      wdata[15:0] (SH, lane addr[1]); mem_sw=1, mem_write_addr=captured addr, mem_write_data=merged;
//      ack resp_valid=1 at T+2; -> IDLE.
//  - Latency: LW/LB/LH/LBU/LHU 2 cycles, SW 1, SB/SH 2, error 1. Throughput: new accept allowed in the
//    cycle resp_valid is high.
//  - mem_write_addr=req word addr in IDLE, captured word addr otherwise; mem_write_data 0 when mem_sw=0.
//  - Store followed by a load to the same word: ordering is guaranteed; the write lands on the edge ending
//    the mem_sw cycle, and the next read is issued no earlier than that cycle.
//  - reset asserted mid-operation: aborts; a pending RMW write is dropped and the memory word is unchanged.
//  - req_ready=0 outside IDLE; req_valid held high while not ready is ignored, not queued.
// STRUCTURE
//  - lsu_pkg: funct3 constants (F3_B,F3_H,F3_W,F3_BU,F3_HU), state enum encoding, WORD_AW default.
//  - Sub-module lsu_align (combinational): load extract/extend and store lane merge; top holds FSM/regs.
// TESTING (bench models data_memory with 1-cycle registered read)
//  - SW addr 0x08 wdata 0xDEADBEEF -> mem_sw at T, word[2]=0xDEADBEEF, ack T+1 err=0.
//  - After above: LB 0x0B -> 0xFFFFFFDE; LBU 0x0B -> 0x000000DE; LH 0x08 -> 0xFFFFBEEF; LW 0x08 -> 0xDEADBEEF, all at T+2.
//  - SB 0x09 wdata 0x12 then LW 0x08 -> 0xDEAD12EF; SH 0x0A wdata 0x5678 then LW -> 0x567812EF.
//  - LH 0x05, LW 0x06, SW 0x80 (WORD_AW=5), funct3 011 -> resp_err=1 at T+1, rdata 0, no mem_sw, memory unchanged.
//  - Back-to-back: SB accepted at T, LW same word accepted at T+2 -> LW returns merged value at T+4.
//  - Drop reset in RMW_WAIT -> mem_sw=0 that cycle, resp_valid=0, state IDLE, word unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and types for the load/store unit.
//   F3_*        RV32I funct3 size/sign codes for loads and stores
//   lsu_state_e FSM state encoding (IDLE, LD_WAIT, RMW_WAIT)
//   WORD_AW_DEF default word-address width (32-word data_memory)
package lsu_pkg;

    localparam int WORD_AW_DEF = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LD_WAIT  = 2'd1,
        ST_RMW_WAIT = 2'd2
    } lsu_state_e;

    // Stores only come in B/H/W; loads add the unsigned B/H forms.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: bus bundle between execute stage, load/store unit and data_memory.
//   req_*  request from execute (valid/ready handshake)
//   resp_* one-cycle response pulse back to execute
//   mem_*  word-wide data_memory read/write ports
//   slave  = load/store unit view, master = execute + memory view
interface lsu_if #(parameter int WORD_AW = 5);

    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [2:0]         req_funct3;
    logic [31:0]        req_addr;
    logic [31:0]        req_wdata;
    logic               resp_valid;
    logic [31:0]        resp_rdata;
    logic               resp_err;
    logic [WORD_AW-1:0] mem_read_addr;
    logic [WORD_AW-1:0] mem_write_addr;
    logic [31:0]        mem_write_data;
    logic               mem_sw;
    logic [31:0]        mem_read_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_read_addr, mem_write_addr, mem_write_data, mem_sw
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_read_addr, mem_write_addr, mem_write_data, mem_sw
    );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational byte/half lane handling.
//   i_f3      captured funct3
//   i_off     captured byte offset within the word
//   i_rdata   word read from data_memory
//   i_wdata   low 16 bits of store data
//   o_ld_data sign/zero-extended load result
//   o_st_data read word with the store lane(s) replaced
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_f3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rdata,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_st_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    assign w_byte   = i_rdata[8*i_off +: 8];
    assign w_half   = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    // funct3[2] set marks the unsigned (BU/HU) load forms.
    assign w_signed = ~i_f3[2];

    always_comb begin
        o_ld_data = i_rdata;
        case (i_f3[1:0])
            2'b00:   o_ld_data = {{24{w_signed & w_byte[7]}}, w_byte};
            2'b01:   o_ld_data = {{16{w_signed & w_half[15]}}, w_half};
            default: o_ld_data = i_rdata;
        endcase
    end

    always_comb begin
        o_st_data = i_rdata;
        if (i_f3 == F3_B)
            o_st_data[8*i_off +: 8] = i_wdata[7:0];
        else if (i_f3 == F3_H)
            o_st_data[16*i_off[1] +: 16] = i_wdata;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte-addressed load/store front end for a
// word-wide data_memory with a 1-cycle registered read.
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    lsu_if.slave: req_* handshake in, resp_* pulse out, mem_* ports
// Latency: SW and errors 1 cycle, loads and SB/SH (read-modify-write) 2.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WORD_AW = WORD_AW_DEF
) (
    input  logic  clk,
    input  logic  reset,
    lsu_if.slave  bus
);

    lsu_state_e         r_state, w_next;
    logic [1:0]         r_off;
    logic [2:0]         r_f3;
    logic [15:0]        r_wdata;
    logic [WORD_AW-1:0] r_waddr;
    logic               r_resp_valid;
    logic [31:0]        r_resp_rdata;
    logic               r_resp_err;

    logic               w_idle, w_accept, w_err, w_is_sw, w_misalign;
    logic [WORD_AW-1:0] w_req_waddr;
    logic [31:0]        w_ld_data, w_st_data;
    logic               w_mem_sw;
    logic [31:0]        w_mem_wdata;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = bus.req_valid & w_idle;
    assign w_req_waddr = bus.req_addr[WORD_AW+1:2];
    assign w_is_sw     = bus.req_we & (bus.req_funct3 == F3_W);

    always_comb begin
        w_misalign = 1'b0;
        case (bus.req_funct3)
            F3_H, F3_HU: w_misalign = bus.req_addr[0];
            F3_W:        w_misalign = (bus.req_addr[1:0] != 2'b00);
            default:     w_misalign = 1'b0;
        endcase
    end

    assign w_err = ~f3_legal(bus.req_we, bus.req_funct3) | w_misalign |
                   (bus.req_addr[31:WORD_AW+2] != '0);

    lsu_align u_align (
        .i_f3      (r_f3),
        .i_off     (r_off),
        .i_rdata   (bus.mem_read_data),
        .i_wdata   (r_wdata),
        .o_ld_data (w_ld_data),
        .o_st_data (w_st_data)
    );

    always_comb begin
        w_next      = r_state;
        w_mem_sw    = 1'b0;
        w_mem_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_err) begin
                    if (!bus.req_we) begin
                        w_next = ST_LD_WAIT;
                    end else if (w_is_sw) begin
                        // Full-word store goes straight through, no read needed.
                        w_mem_sw    = 1'b1;
                        w_mem_wdata = bus.req_wdata;
                    end else begin
                        w_next = ST_RMW_WAIT;
                    end
                end
            end
            ST_LD_WAIT: w_next = ST_IDLE;
            ST_RMW_WAIT: begin
                w_next      = ST_IDLE;
                w_mem_sw    = 1'b1;
                w_mem_wdata = w_st_data;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_off        <= '0;
            r_f3         <= '0;
            r_wdata      <= '0;
            r_waddr      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_off   <= bus.req_addr[1:0];
                r_f3    <= bus.req_funct3;
                r_wdata <= bus.req_wdata[15:0];
                r_waddr <= w_req_waddr;
            end
            // Every non-idle state ends in a response; from IDLE only SW and errors do.
            r_resp_valid <= (w_accept & (w_err | w_is_sw)) | ~w_idle;
            r_resp_err   <= w_accept & w_err;
            r_resp_rdata <= (r_state == ST_LD_WAIT) ? w_ld_data : '0;
        end
    end

    assign bus.req_ready      = w_idle;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_rdata     = r_resp_rdata;
    assign bus.resp_err       = r_resp_err;
    assign bus.mem_read_addr  = w_idle ? w_req_waddr : r_waddr;
    assign bus.mem_write_addr = w_idle ? w_req_waddr : r_waddr;
    assign bus.mem_write_data = w_mem_wdata;
    assign bus.mem_sw         = w_mem_sw;

endmodule
